// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer and the lab5 datapath ALU.
// State codes are 3 bits wide; op codes match the ALU select inputs.
package alu_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      EXEC   = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5
   } seq_state_t;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_NOTB = 2'b11;

endpackage

// File: rtl/alu_sequencer.sv
// Control FSM driving the register-file/ALU datapath, one command at a time.
// Optional macro ALU_SEQ_SKIP_A_EN: op NOT-B skips the unused operand-A load.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int REG_IDX_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic                 cmd_nowb,
   input  logic [REG_IDX_W-1:0] cmd_rd,
   input  logic [REG_IDX_W-1:0] cmd_rn,
   input  logic [REG_IDX_W-1:0] cmd_rm,
   output logic [REG_IDX_W-1:0] readnum,
   output logic [REG_IDX_W-1:0] writenum,
   output logic                 write,
   output logic                 loada,
   output logic                 loadb,
   output logic                 loadc,
   output logic                 loads,
   output logic [1:0]           ALUop,
   output logic                 done
);

   seq_state_t           r_state;
   seq_state_t           w_next;
   logic [1:0]           r_op;
   logic                 r_nowb;
   logic [REG_IDX_W-1:0] r_rd;
   logic [REG_IDX_W-1:0] r_rn;
   logic [REG_IDX_W-1:0] r_rm;
   logic                 w_hs;

   assign w_hs = cmd_valid & cmd_ready;

   // State register; reset aborts any command in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Capture command fields only on the accepting edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op   <= '0;
         r_nowb <= 1'b0;
         r_rd   <= '0;
         r_rn   <= '0;
         r_rm   <= '0;
      end else if (w_hs) begin
         r_op   <= cmd_op;
         r_nowb <= cmd_nowb;
         r_rd   <= cmd_rd;
         r_rn   <= cmd_rn;
         r_rm   <= cmd_rm;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_hs) begin
`ifdef ALU_SEQ_SKIP_A_EN
               if (cmd_op == ALU_NOTB) begin
                  w_next = LOAD_B;
               end else begin
                  w_next = LOAD_A;
               end
`else
               w_next = LOAD_A;
`endif
            end
         end
         LOAD_A: w_next = LOAD_B;
         LOAD_B: w_next = EXEC;
         EXEC: begin
            if (r_nowb) begin
               w_next = DONE;
            end else begin
               w_next = WRITE;
            end
         end
         WRITE:   w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Moore output decode from the state and captured fields.
   always_comb begin
      cmd_ready = 1'b0;
      readnum   = '0;
      writenum  = '0;
      write     = 1'b0;
      loada     = 1'b0;
      loadb     = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      ALUop     = 2'b00;
      done      = 1'b0;
      unique case (r_state)
         IDLE: cmd_ready = 1'b1;
         LOAD_A: begin
            readnum = r_rn;
            loada   = 1'b1;
         end
         LOAD_B: begin
            readnum = r_rm;
            loadb   = 1'b1;
         end
         EXEC: begin
            ALUop = r_op;
            loadc = 1'b1;
            loads = 1'b1;
         end
         WRITE: begin
            writenum = r_rd;
            write    = 1'b1;
         end
         DONE:    done = 1'b1;
         default: cmd_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural datapath.
// Define ALU_SEQ_SKIP_A_EN for both RTL and bench to test the skip path.
module tb_alu_sequencer;

`ifdef ALU_SEQ_SKIP_A_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic        cmd_nowb;
   logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
   logic [2:0]  readnum, writenum;
   logic        write, loada, loadb, loadc, loads, done;
   logic [1:0]  ALUop;

   int n_chk = 0;
   int n_fail = 0;

   alu_sequencer #(.REG_IDX_W(3)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_nowb(cmd_nowb),
      .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
      .readnum(readnum), .writenum(writenum),
      .write(write), .loada(loada), .loadb(loadb),
      .loadc(loadc), .loads(loads),
      .ALUop(ALUop), .done(done)
   );

   always #5 clk = ~clk;

   // Behavioural register file, operand/result registers and status.
   logic [15:0] regs [8];
   logic [15:0] ra, rb, rc, alu;
   logic        rz;
   logic        dp_init, clr;
   int          c_la, c_lb, c_lc, c_ls, c_wr, c_dn;

   always_comb begin
      alu = 16'h0;
      case (ALUop)
         2'b00: alu = ra + rb;
         2'b01: alu = ra - rb;
         2'b10: alu = ra & rb;
         2'b11: alu = ~rb;
         default: alu = 16'h0;
      endcase
   end

   always @(posedge clk) begin
      if (dp_init) begin
         for (int i = 0; i < 8; i++) regs[i] <= 16'(i * 3 + 1);
      end else begin
         if (write) regs[writenum] <= rc;
         if (loada) ra <= regs[readnum];
         if (loadb) rb <= regs[readnum];
         if (loadc) rc <= alu;
         if (loads) rz <= (alu == 16'h0);
      end
   end

   always @(posedge clk) begin
      if (clr) begin
         c_la <= 0; c_lb <= 0; c_lc <= 0;
         c_ls <= 0; c_wr <= 0; c_dn <= 0;
      end else begin
         c_la <= c_la + int'(loada);
         c_lb <= c_lb + int'(loadb);
         c_lc <= c_lc + int'(loadc);
         c_ls <= c_ls + int'(loads);
         c_wr <= c_wr + int'(write);
         c_dn <= c_dn + int'(done);
      end
   end

   wire [14:0] outv = {cmd_ready, readnum, writenum, write, loada,
                       loadb, loadc, loads, ALUop, done};

   function automatic logic [14:0] vec(
      input bit rdy, input logic [2:0] rn, input logic [2:0] wn,
      input bit wr, input bit la, input bit lb, input bit lc,
      input bit ls, input logic [1:0] op, input bit dn);
      return {rdy, rn, wn, wr, la, lb, lc, ls, op, dn};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   // Present a command in IDLE and check every cycle through DONE.
   task automatic run_cmd(input string tag, input logic [1:0] op,
                          input bit nowb, input logic [2:0] rd,
                          input logic [2:0] rn, input logic [2:0] rm,
                          input bit hold);
      cmd_valid = 1'b1;
      cmd_op = op; cmd_nowb = nowb;
      cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
      check({tag, ":idle"}, 32'(outv), 32'(vec(1,0,0,0,0,0,0,0,0,0)));
      step();
      if (!hold) cmd_valid = 1'b0;
      cmd_op = 2'($urandom); cmd_nowb = 1'($urandom);
      cmd_rd = 3'($urandom); cmd_rn = 3'($urandom);
      cmd_rm = 3'($urandom);
      if (!(SKIP && op == 2'b11)) begin
         check({tag, ":lda"}, 32'(outv), 32'(vec(0,rn,0,0,1,0,0,0,0,0)));
         step();
      end
      check({tag, ":ldb"}, 32'(outv), 32'(vec(0,rm,0,0,0,1,0,0,0,0)));
      step();
      check({tag, ":exe"}, 32'(outv), 32'(vec(0,0,0,0,0,0,1,1,op,0)));
      step();
      if (!nowb) begin
         check({tag, ":wr"}, 32'(outv), 32'(vec(0,0,rd,1,0,0,0,0,0,0)));
         step();
      end
      check({tag, ":done"}, 32'(outv), 32'(vec(0,0,0,0,0,0,0,0,0,1)));
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_nowb = 1'b0;
      cmd_rd = 3'd0; cmd_rn = 3'd0; cmd_rm = 3'd0;
      dp_init = 1'b1; clr = 1'b1;
      #2;
      check("rst_async", 32'(outv), 32'(vec(1,0,0,0,0,0,0,0,0,0)));
      step(); step();
      check("rst_held", 32'(outv), 32'(vec(1,0,0,0,0,0,0,0,0,0)));
      @(negedge clk);
      reset = 1'b0; dp_init = 1'b0; clr = 1'b0;
      step();

      // Add r3 = r1 + r2 = 4 + 7
      run_cmd("add", 2'b00, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0);
      step();
      check("add_r3", 32'(regs[3]), 32'd11);
      check("add_z", 32'(rz), 32'd0);

      // Compare r5 - r5: status only
      clear_counts();
      run_cmd("cmp", 2'b01, 1'b1, 3'd0, 3'd5, 3'd5, 1'b0);
      step();
      check("cmp_z", 32'(rz), 32'd1);
      check("cmp_nowr", 32'(c_wr), 32'd0);
      check("cmp_r0", 32'(regs[0]), 32'd1);

      // Valid held high, fields scrambled during the command
      run_cmd("hold1", 2'b10, 1'b0, 3'd7, 3'd1, 3'd2, 1'b1);
      step();
      run_cmd("hold2", 2'b00, 1'b0, 3'd6, 3'd3, 3'd0, 1'b1);
      cmd_valid = 1'b0;
      step();
      check("hold1_r7", 32'(regs[7]), 32'd4);
      check("hold2_r6", 32'(regs[6]), 32'd12);
      check("hold_idle", 32'(outv), 32'(vec(1,0,0,0,0,0,0,0,0,0)));

      // Not-B r4 = ~r4
      clear_counts();
      run_cmd("notb", 2'b11, 1'b0, 3'd4, 3'd0, 3'd4, 1'b0);
      step();
      check("notb_r4", 32'(regs[4]), 32'h0000fff2);
      check("notb_la", 32'(c_la), SKIP ? 32'd0 : 32'd1);

      // Aliased add r6 = r6 + r6
      clear_counts();
      run_cmd("alias", 2'b00, 1'b0, 3'd6, 3'd6, 3'd6, 1'b0);
      step();
      check("alias_r6", 32'(regs[6]), 32'd24);
      check("alias_cnt",
            32'({c_la[3:0], c_lb[3:0], c_lc[3:0], c_ls[3:0],
                 c_wr[3:0], c_dn[3:0]}), 32'h00111111);

      // Reset pulse while in EXEC aborts the command
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_nowb = 1'b0;
      cmd_rd = 3'd5; cmd_rn = 3'd1; cmd_rm = 3'd1;
      step();
      cmd_valid = 1'b0;
      step(); step();
      check("rst_exec_lc", 32'(loadc), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid", 32'(outv), 32'(vec(1,0,0,0,0,0,0,0,0,0)));
      @(negedge clk);
      reset = 1'b0;
      clear_counts();
      repeat (6) step();
      check("rst_nowr", 32'(c_wr), 32'd0);
      check("rst_nodn", 32'(c_dn), 32'd0);
      check("rst_r5", 32'(regs[5]), 32'd16);
      check("rst_ready", 32'(cmd_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
